// File: rtl/usb_tx_sched_if.sv
// Bundle of the usb_tx_sched request/grant, back-pressure and serial-out signals.
// slave = the scheduler, master = requesters plus the downstream CRC/wire path.
interface usb_tx_sched_if;
    logic        hs_req;
    logic [7:0]  hs_pid;
    logic        hs_ack;
    logic        tok_req;
    logic [7:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        tok_ack;
    logic        data_req;
    logic [7:0]  data_pid;
    logic [63:0] data_payload;
    logic        data_ack;
    logic        hold;
    logic        tx_done;
    logic        s_out;
    logic        start;
    logic        endr;
    logic [1:0]  pkt_type;
    logic        busy;

    modport slave (
        input  hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
        input  data_req, data_pid, data_payload, hold, tx_done,
        output hs_ack, tok_ack, data_ack, s_out, start, endr, pkt_type, busy
    );

    modport master (
        output hs_req, hs_pid, tok_req, tok_pid, tok_addr, tok_endp,
        output data_req, data_pid, data_payload, hold, tx_done,
        input  hs_ack, tok_ack, data_ack, s_out, start, endr, pkt_type, busy
    );
endinterface

// File: rtl/usb_tx_sched.sv
// USB transmit scheduler: fixed-priority grant, bit-serial SYNC/PID/payload feed to CRC stage.
// Optional inter-packet gap state enabled by defining USB_TX_IPG_EN.
module usb_tx_sched #(
    parameter int IPG_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    usb_tx_sched_if.slave   sched
);

    localparam logic [7:0] SYNC     = 8'h80;   // seven 0s then a 1, LSB first on the wire
    localparam int         LEN_HS   = 16;
    localparam int         LEN_TOK  = 27;
    localparam int         LEN_DATA = 80;

    localparam logic [1:0] PT_DATA  = 2'd0;
    localparam logic [1:0] PT_TOK   = 2'd1;
    localparam logic [1:0] PT_HS    = 2'd2;

    if (IPG_CYCLES < 1 || IPG_CYCLES > 63) begin : g_ipg_range_bad
        $error("usb_tx_sched: IPG_CYCLES must be 1..63");
    end

`ifdef USB_TX_IPG_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE, S_GAP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_DONE} state_e;
`endif

    state_e      state_q, state_d;
    logic [79:0] shift_q, shift_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic        first_q, first_d;
    logic [1:0]  pkt_type_q, pkt_type_d;
`ifdef USB_TX_IPG_EN
    logic [5:0]  gap_cnt_q, gap_cnt_d;
`endif

    logic idle, xfer, last_bit;
    logic grant_hs, grant_tok, grant_data;

    assign idle       = (state_q == S_IDLE);
    assign xfer       = (state_q == S_SEND) && !sched.hold;
    assign last_bit   = (bit_cnt_q == 7'd0);
    assign grant_hs   = idle && sched.hs_req;
    assign grant_tok  = idle && !sched.hs_req && sched.tok_req;
    assign grant_data = idle && !sched.hs_req && !sched.tok_req && sched.data_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            first_q    <= 1'b0;
            pkt_type_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            first_q    <= first_d;
            pkt_type_q <= pkt_type_d;
        end
    end

`ifdef USB_TX_IPG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_cnt_q <= '0;
        else        gap_cnt_q <= gap_cnt_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        first_d    = first_q;
        pkt_type_d = pkt_type_q;
`ifdef USB_TX_IPG_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_hs) begin
                    shift_d    = {64'b0, sched.hs_pid, SYNC};
                    bit_cnt_d  = 7'(LEN_HS - 1);
                    pkt_type_d = PT_HS;
                    first_d    = 1'b1;
                    state_d    = S_SEND;
                end else if (grant_tok) begin
                    shift_d    = {53'b0, sched.tok_endp, sched.tok_addr, sched.tok_pid, SYNC};
                    bit_cnt_d  = 7'(LEN_TOK - 1);
                    pkt_type_d = PT_TOK;
                    first_d    = 1'b1;
                    state_d    = S_SEND;
                end else if (grant_data) begin
                    shift_d    = {sched.data_payload, sched.data_pid, SYNC};
                    bit_cnt_d  = 7'(LEN_DATA - 1);
                    pkt_type_d = PT_DATA;
                    first_d    = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                // hold freezes everything, so s_out keeps presenting the pending bit
                if (xfer) begin
                    shift_d = {1'b0, shift_q[79:1]};
                    first_d = 1'b0;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        state_d   = S_WAIT_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 7'd1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (sched.tx_done) begin
`ifdef USB_TX_IPG_EN
                    gap_cnt_d = 6'(IPG_CYCLES - 1);
                    state_d   = S_GAP;
`else
                    state_d   = S_IDLE;
`endif
                end
            end
`ifdef USB_TX_IPG_EN
            S_GAP: begin
                if (gap_cnt_q == 6'd0) state_d = S_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 6'd1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // acks are combinational so the grant lands in the request cycle; gated off during reset
    assign sched.hs_ack   = rst_n && grant_hs;
    assign sched.tok_ack  = rst_n && grant_tok;
    assign sched.data_ack = rst_n && grant_data;

    assign sched.s_out    = shift_q[0];
    assign sched.start    = xfer && first_q;
    assign sched.endr     = xfer && last_bit;
    assign sched.pkt_type = pkt_type_q;
    assign sched.busy     = !idle;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: stimulus queues expected bits/acks, a monitor checks them.
module tb_usb_tx_sched;
    localparam int IPG = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb_tx_sched_if u();
    usb_tx_sched #(.IPG_CYCLES(IPG)) dut (.clk(clk), .rst_n(rst_n), .sched(u.slave));

    typedef struct {
        logic       b;
        logic       st;
        logic       en;
        logic [1:0] pt;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic in_pkt = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic push_str(input string s, input logic [1:0] pt);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back('{b: (s[i] == 8'h31), st: (i == 0), en: (i == s.len() - 1), pt: pt});
    endtask

    task automatic push_vec(input logic [79:0] v, input int len, input logic [1:0] pt);
        for (int i = 0; i < len; i++)
            exp_q.push_back('{b: v[i], st: (i == 0), en: (i == len - 1), pt: pt});
    endtask

    // Monitor: acks and transfers are compared as the DUT presents them
    always @(negedge clk) begin
        int   na;
        exp_t e;
        if (!rst_n) begin
            in_pkt = 1'b0;
        end else begin
            na = int'(u.hs_ack) + int'(u.tok_ack) + int'(u.data_ack);
            if (na != 0) begin
                chk("ack_onehot", 64'(na), 64'd1);
                if (ack_q.size() == 0) chk("ack_unexpected", 64'(na), 64'd0);
                else chk("ack_order", u.tok_ack ? 64'd1 : (u.data_ack ? 64'd2 : 64'd0),
                         64'(ack_q.pop_front()));
            end
            if (u.hold && (in_pkt || u.start)) begin
                chk("hold_start", {63'b0, u.start}, 64'd0);
                chk("hold_endr", {63'b0, u.endr}, 64'd0);
                if (exp_q.size() != 0) chk("hold_sout", {63'b0, u.s_out}, {63'b0, exp_q[0].b});
            end else if (in_pkt || u.start) begin
                if (exp_q.size() == 0) begin
                    chk("bit_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("s_out", {63'b0, u.s_out}, {63'b0, e.b});
                    chk("start", {63'b0, u.start}, {63'b0, e.st});
                    chk("endr", {63'b0, u.endr}, {63'b0, e.en});
                    chk("pkt_type", {62'b0, u.pkt_type}, {62'b0, e.pt});
                end
                in_pkt = !u.endr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int who);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((who == 0 && u.hs_ack) || (who == 1 && u.tok_ack) || (who == 2 && u.data_ack)) return;
        end
        chk("ack_timeout", 64'd0, 64'(who));
    endtask

    task automatic wait_endr();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u.endr) return;
        end
        chk("endr_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_done(input int dly);
        repeat (dly) tick();
        u.tx_done = 1'b1;
        tick();
        u.tx_done = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_sout"}, {63'b0, u.s_out}, 64'd0);
        chk({tag, "_start_endr"}, {62'b0, u.start, u.endr}, 64'd0);
        chk({tag, "_pkt_type"}, {62'b0, u.pkt_type}, 64'd0);
        chk({tag, "_acks"}, {61'b0, u.hs_ack, u.tok_ack, u.data_ack}, 64'd0);
        chk({tag, "_busy"}, {63'b0, u.busy}, 64'd0);
    endtask

    initial begin
        u.hs_req = 0; u.hs_pid = '0; u.tok_req = 0; u.tok_pid = '0; u.tok_addr = '0;
        u.tok_endp = '0; u.data_req = 0; u.data_pid = '0; u.data_payload = '0;
        u.hold = 0; u.tx_done = 0;
        #12;
        outs_zero("reset");
        rst_n = 1'b1;
        tick();

        // handshake D2
        ack_q.push_back(0);
        push_str("0000000101001011", 2'd2);
        u.hs_pid = 8'hD2; u.hs_req = 1;
        wait_ack(0); tick(); u.hs_req = 0;
        wait_endr(); pulse_done(3);

        // token 69 / 3A / 1
        ack_q.push_back(1);
        push_str({"00000001", "10010110", "0101110", "1000"}, 2'd1);
        u.tok_pid = 8'h69; u.tok_addr = 7'h3A; u.tok_endp = 4'h1; u.tok_req = 1;
        wait_ack(1); tick(); u.tok_req = 0;
        wait_endr(); pulse_done(3);

        // simultaneous requests: hs, then tok, then data
        ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(2);
        push_vec({64'b0, 8'h5A, 8'h80}, 16, 2'd2);
        push_vec({53'b0, 4'h7, 7'h05, 8'hE1, 8'h80}, 27, 2'd1);
        push_vec({64'h0011_2233_4455_6677, 8'hC3, 8'h80}, 80, 2'd0);
        u.hs_pid = 8'h5A; u.tok_pid = 8'hE1; u.tok_addr = 7'h05; u.tok_endp = 4'h7;
        u.data_pid = 8'hC3; u.data_payload = 64'h0011_2233_4455_6677;
        u.hs_req = 1; u.tok_req = 1; u.data_req = 1;
        wait_ack(0); tick(); u.hs_req = 0;
        wait_endr(); pulse_done(3);
        wait_ack(1); tick(); u.tok_req = 0;
        wait_endr(); pulse_done(3);
        wait_ack(2); tick(); u.data_req = 0;
        wait_endr(); pulse_done(3);

        // back-pressure across bits 10..14 of a data packet
        ack_q.push_back(2);
        push_vec({64'hA5A5_0000_FFFF_1234, 8'h4B, 8'h80}, 80, 2'd0);
        u.data_pid = 8'h4B; u.data_payload = 64'hA5A5_0000_FFFF_1234; u.data_req = 1;
        wait_ack(2); tick(); u.data_req = 0;
        repeat (9) tick();
        u.hold = 1;
        repeat (5) tick();
        u.hold = 0;
        wait_endr(); pulse_done(3);

        // tx_done withheld: pending token must wait
        ack_q.push_back(0); ack_q.push_back(1);
        push_vec({64'b0, 8'hD2, 8'h80}, 16, 2'd2);
        push_vec({53'b0, 4'h2, 7'h11, 8'h2D, 8'h80}, 27, 2'd1);
        u.hs_pid = 8'hD2; u.hs_req = 1;
        wait_ack(0); tick(); u.hs_req = 0;
        u.tok_pid = 8'h2D; u.tok_addr = 7'h11; u.tok_endp = 4'h2; u.tok_req = 1;
        wait_endr();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0 || i == 49) chk("withheld_busy_ack", {62'b0, u.busy, u.tok_ack}, 64'd2);
        end
        pulse_done(1);
`ifdef USB_TX_IPG_EN
        for (int i = 0; i < IPG; i++) begin
            @(negedge clk);
            chk("gap_busy_ack", {62'b0, u.busy, u.tok_ack}, 64'd2);
            tick();
        end
`endif
        @(negedge clk);
        chk("ack_latency", {63'b0, u.tok_ack}, 64'd1);
        tick(); u.tok_req = 0;
        wait_endr(); pulse_done(3);

        // reset at bit 40 of a data packet; request stays up and is re-granted
        ack_q.push_back(2); ack_q.push_back(2);
        push_vec({64'h0123_4567_89AB_CDEF, 8'hC3, 8'h80}, 80, 2'd0);
        u.data_pid = 8'hC3; u.data_payload = 64'h0123_4567_89AB_CDEF; u.data_req = 1;
        wait_ack(2);
        repeat (40) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        outs_zero("midpkt_reset");
        push_vec({64'h0123_4567_89AB_CDEF, 8'hC3, 8'h80}, 80, 2'd0);
        tick();
        rst_n = 1'b1;
        wait_ack(2); tick(); u.data_req = 0;
        wait_endr(); pulse_done(3);

        repeat (20) tick();
        chk("bits_left", 64'(exp_q.size()), 64'd0);
        chk("acks_left", 64'(ack_q.size()), 64'd0);
        chk("idle_busy", {63'b0, u.busy}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
